// File: rtl/spi_bus_arbiter_if.sv
// Requester-side snd/cmd/done/resp pairs, the SPI monarch handshake and status flags.
// The slave modport is the arbiter; the master modport is whatever drives requests and models the monarch.
interface spi_bus_arbiter_if;
    logic        snd0;
    logic [15:0] cmd0;
    logic        done0;
    logic [7:0]  resp0;
    logic        snd1;
    logic [15:0] cmd1;
    logic        done1;
    logic [7:0]  resp1;
    logic        mn_snd;
    logic [15:0] mn_cmd;
    logic        mn_done;
    logic [7:0]  mn_resp;
    logic [1:0]  gnt;
    logic [1:0]  ovr_err;
    logic        tmo_err;

    modport slave (
        input  snd0, cmd0, snd1, cmd1, mn_done, mn_resp,
        output done0, resp0, done1, resp1, mn_snd, mn_cmd, gnt, ovr_err, tmo_err
    );

    modport master (
        output snd0, cmd0, snd1, cmd1, mn_done, mn_resp,
        input  done0, resp0, done1, resp1, mn_snd, mn_cmd, gnt, ovr_err, tmo_err
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI monarch between two requesters; snd->mn_snd 2 clks, done edge->doneX 2 clks.
// No backpressure: one request is queued per port, a second snd while queued is dropped and flagged in ovr_err.
module spi_bus_arbiter #(
    parameter int TMO_CYC = 1024
) (
    input  logic            clk,
    input  logic            rst,
    spi_bus_arbiter_if.slave bus
);
    localparam int WD_W = $clog2(TMO_CYC);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, RETIRE} state_t;

    state_t          state, state_nxt;
    logic            pend0, pend1;
    logic [15:0]     cmd0_q, cmd1_q;
    logic            rr, own, done_q;
    logic [WD_W-1:0] wd;
    logic            load, sel, complete, timeout, retire;

    logic            mn_snd_q, done0_q, done1_q, tmo_q;
    logic [15:0]     mn_cmd_q;
    logic [7:0]      resp0_q, resp1_q;
    logic [1:0]      gnt_q, ovr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        sel       = own;
        complete  = 1'b0;
        timeout   = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                if (pend0 || pend1) begin
                    load      = 1'b1;
                    sel       = (pend0 && pend1) ? rr : pend1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = XFER;
            XFER: begin
                // Only a fresh rising edge completes; a done level left over from the last transfer is ignored.
                if (bus.mn_done && !done_q) begin
                    complete  = 1'b1;
                    state_nxt = RETIRE;
                end else if (wd == WD_W'(TMO_CYC - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = RETIRE;
                end
            end
            RETIRE: begin
                retire    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture: a snd while the port already has a queued request keeps the older command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend0  <= 1'b0;
            pend1  <= 1'b0;
            cmd0_q <= '0;
            cmd1_q <= '0;
            ovr_q  <= 2'b00;
        end else begin
            pend0 <= (pend0 && !(load && !sel)) || (bus.snd0 && !pend0);
            pend1 <= (pend1 && !(load && sel))  || (bus.snd1 && !pend1);
            if (bus.snd0 && !pend0) cmd0_q <= bus.cmd0;
            if (bus.snd1 && !pend1) cmd1_q <= bus.cmd1;
            if (bus.snd0 && pend0)  ovr_q[0] <= 1'b1;
            if (bus.snd1 && pend1)  ovr_q[1] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr       <= 1'b0;
            own      <= 1'b0;
            done_q   <= 1'b0;
            wd       <= '0;
            mn_snd_q <= 1'b0;
            mn_cmd_q <= '0;
            gnt_q    <= 2'b00;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            resp0_q  <= '0;
            resp1_q  <= '0;
            tmo_q    <= 1'b0;
        end else begin
            done_q   <= bus.mn_done;
            mn_snd_q <= load;
            done0_q  <= retire && !own;
            done1_q  <= retire && own;
            if (load) begin
                own      <= sel;
                mn_cmd_q <= sel ? cmd1_q : cmd0_q;
                gnt_q    <= sel ? 2'b10 : 2'b01;
            end
            if (state == ISSUE)     wd <= '0;
            else if (state == XFER) wd <= wd + 1'b1;
            if (complete) begin
                if (own) resp1_q <= bus.mn_resp;
                else     resp0_q <= bus.mn_resp;
            end
            if (timeout) begin
                if (own) resp1_q <= 8'hFF;
                else     resp0_q <= 8'hFF;
                tmo_q <= 1'b1;
            end
            if (retire) begin
                rr    <= !own;
                gnt_q <= 2'b00;
            end
        end
    end

    assign bus.mn_snd  = mn_snd_q;
    assign bus.mn_cmd  = mn_cmd_q;
    assign bus.gnt     = gnt_q;
    assign bus.done0   = done0_q;
    assign bus.done1   = done1_q;
    assign bus.resp0   = resp0_q;
    assign bus.resp1   = resp1_q;
    assign bus.ovr_err = ovr_q;
    assign bus.tmo_err = tmo_q;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: a table of single-port transactions plus hand-written arbitration,
// overrun, timeout and mid-transfer reset sequences.
module tb_spi_bus_arbiter;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nmis = 0;
    int   dcnt0 = 0;
    int   dcnt1 = 0;
    int   scnt = 0;

    spi_bus_arbiter_if bus();

    spi_bus_arbiter #(.TMO_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.done0 === 1'b1)  dcnt0++;
        if (bus.done1 === 1'b1)  dcnt1++;
        if (bus.mn_snd === 1'b1) scnt++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1);
    end

    typedef struct {
        logic        port;
        logic [15:0] cmd;
        logic [7:0]  mresp;
        int          dly;
        logic [1:0]  egnt;
        logic [7:0]  eresp;
    } vec_t;

    vec_t       vt[5];
    logic [7:0] er[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_done(input logic p);
        return p ? bus.done1 : bus.done0;
    endfunction

    function automatic logic [7:0] get_resp(input logic p);
        return p ? bus.resp1 : bus.resp0;
    endfunction

    task automatic send(input logic p, input logic [15:0] c);
        if (p) begin bus.snd1 = 1'b1; bus.cmd1 = c; end
        else   begin bus.snd0 = 1'b1; bus.cmd0 = c; end
        tick();
        bus.snd0 = 1'b0;
        bus.snd1 = 1'b0;
    endtask

    task automatic wait_snd(input string name);
        int n = 0;
        while (bus.mn_snd !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(name, 32'(bus.mn_snd), 32'd1);
    endtask

    // Entered in the issue cycle or later; returns two cycles after the done edge.
    task automatic finish_xfer(input logic [7:0] r);
        bus.mn_done = 1'b0;
        tick();
        bus.mn_done = 1'b1;
        bus.mn_resp = r;
        tick();
        tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        er[0] = 8'h00;
        er[1] = 8'h00;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " gnt"},     32'(bus.gnt),     32'd0);
        chk({tag, " mn_snd"},  32'(bus.mn_snd),  32'd0);
        chk({tag, " mn_cmd"},  32'(bus.mn_cmd),  32'd0);
        chk({tag, " done"},    32'({bus.done1, bus.done0}), 32'd0);
        chk({tag, " resp0"},   32'(bus.resp0),   32'd0);
        chk({tag, " resp1"},   32'(bus.resp1),   32'd0);
        chk({tag, " ovr_err"}, 32'(bus.ovr_err), 32'd0);
        chk({tag, " tmo_err"}, 32'(bus.tmo_err), 32'd0);
    endtask

    initial begin
        int   b0, b1, bs, n;
        logic p;

        vt[0] = '{1'b0, 16'h0D02, 8'h5A, 3, 2'b01, 8'h5A};
        vt[1] = '{1'b1, 16'h8000, 8'h3C, 0, 2'b10, 8'h3C};
        vt[2] = '{1'b0, 16'hA6C3, 8'h00, 5, 2'b01, 8'h00};
        vt[3] = '{1'b1, 16'hFFFF, 8'hFF, 1, 2'b10, 8'hFF};
        vt[4] = '{1'b1, 16'h1234, 8'h81, 2, 2'b10, 8'h81};

        bus.snd0 = 1'b0; bus.cmd0 = '0; bus.snd1 = 1'b0; bus.cmd1 = '0;
        bus.mn_done = 1'b0; bus.mn_resp = '0;
        er[0] = 8'h00; er[1] = 8'h00;
        repeat (2) tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Single-port transactions on an idle bus: exact issue and done latency.
        for (int i = 0; i < 5; i++) begin
            send(vt[i].port, vt[i].cmd);
            tick();
            chk($sformatf("v%0d mn_snd", i), 32'(bus.mn_snd), 32'd1);
            chk($sformatf("v%0d mn_cmd", i), 32'(bus.mn_cmd), 32'(vt[i].cmd));
            chk($sformatf("v%0d gnt", i),    32'(bus.gnt),    32'(vt[i].egnt));
            bus.mn_done = 1'b0;
            repeat (vt[i].dly + 1) tick();
            bus.mn_done = 1'b1;
            bus.mn_resp = vt[i].mresp;
            tick();
            chk($sformatf("v%0d done early", i), 32'(get_done(vt[i].port)), 32'd0);
            tick();
            er[vt[i].port] = vt[i].eresp;
            chk($sformatf("v%0d done", i),       32'(get_done(vt[i].port)),  32'd1);
            chk($sformatf("v%0d other done", i), 32'(get_done(!vt[i].port)), 32'd0);
            chk($sformatf("v%0d resp", i),       32'(get_resp(vt[i].port)),  32'(vt[i].eresp));
            chk($sformatf("v%0d other resp", i), 32'(get_resp(!vt[i].port)), 32'(er[!vt[i].port]));
            chk($sformatf("v%0d gnt idle", i),   32'(bus.gnt), 32'd0);
            tick();
            if (i == 0) chk("v0 done1 never", 32'(dcnt1), 32'd0);
        end

        // Simultaneous requests: port 0 first, port 1 two clocks after retire.
        pulse_reset();
        bus.snd0 = 1'b1; bus.cmd0 = 16'hA6A5;
        bus.snd1 = 1'b1; bus.cmd1 = 16'h8000;
        tick();
        bus.snd0 = 1'b0; bus.snd1 = 1'b0;
        tick();
        chk("both first snd", 32'(bus.mn_snd), 32'd1);
        chk("both first gnt", 32'(bus.gnt),    32'd1);
        chk("both first cmd", 32'(bus.mn_cmd), 32'hA6A5);
        finish_xfer(8'h11);
        chk("both done0", 32'(bus.done0), 32'd1);
        chk("both resp0", 32'(bus.resp0), 32'h11);
        tick();
        chk("both second snd", 32'(bus.mn_snd), 32'd1);
        chk("both second gnt", 32'(bus.gnt),    32'd2);
        chk("both second cmd", 32'(bus.mn_cmd), 32'h8000);
        finish_xfer(8'h22);
        chk("both done1", 32'(bus.done1), 32'd1);
        chk("both done0 quiet", 32'(bus.done0), 32'd0);
        chk("both resp1", 32'(bus.resp1), 32'h22);
        chk("both resp0 kept", 32'(bus.resp0), 32'h11);

        // Both ports re-request on every done: grants must alternate.
        pulse_reset();
        bus.snd0 = 1'b1; bus.cmd0 = 16'hA600;
        bus.snd1 = 1'b1; bus.cmd1 = 16'h8001;
        tick();
        bus.snd0 = 1'b0; bus.snd1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            p = (i % 2) == 1;
            wait_snd($sformatf("rr%0d snd", i));
            chk($sformatf("rr%0d gnt", i), 32'(bus.gnt), p ? 32'd2 : 32'd1);
            chk($sformatf("rr%0d cmd", i), 32'(bus.mn_cmd), p ? 32'h8001 : 32'hA600);
            finish_xfer(8'(i + 8'h40));
            chk($sformatf("rr%0d resp", i), 32'(get_resp(p)), 32'(i + 8'h40));
            if (i < 7) send(p, p ? 16'h8001 : 16'hA600);
        end
        chk("rr ovr_err", 32'(bus.ovr_err), 32'd0);

        // Overrun: a second snd1 while the first is still queued is dropped.
        pulse_reset();
        b1 = dcnt1;
        bus.snd0 = 1'b1; bus.cmd0 = 16'h0D02;
        tick();
        bus.snd0 = 1'b0;
        bus.snd1 = 1'b1; bus.cmd1 = 16'h1111;
        tick();
        chk("ovr issue0 gnt", 32'(bus.gnt), 32'd1);
        bus.cmd1 = 16'h2222;
        tick();
        bus.snd1 = 1'b0;
        chk("ovr flag", 32'(bus.ovr_err), 32'd2);
        finish_xfer(8'h33);
        chk("ovr done0", 32'(bus.done0), 32'd1);
        chk("ovr resp0", 32'(bus.resp0), 32'h33);
        tick();
        chk("ovr issue1 snd", 32'(bus.mn_snd), 32'd1);
        chk("ovr issue1 cmd", 32'(bus.mn_cmd), 32'h1111);
        finish_xfer(8'h44);
        chk("ovr resp1", 32'(bus.resp1), 32'h44);
        repeat (6) tick();
        chk("ovr one done1", 32'(dcnt1 - b1), 32'd1);
        chk("ovr flag sticky", 32'(bus.ovr_err), 32'd2);

        // Timeout: monarch never completes.
        pulse_reset();
        b1 = dcnt1;
        bus.mn_done = 1'b0;
        send(1'b0, 16'h0D03);
        tick();
        chk("tmo snd", 32'(bus.mn_snd), 32'd1);
        n = 0;
        while (bus.done0 !== 1'b1 && n < TMO + 20) begin
            tick();
            n++;
        end
        chk("tmo latency", 32'(n), 32'(TMO + 2));
        chk("tmo resp0", 32'(bus.resp0), 32'hFF);
        chk("tmo flag", 32'(bus.tmo_err), 32'd1);
        chk("tmo no done1", 32'(dcnt1 - b1), 32'd0);
        tick();
        send(1'b1, 16'h4242);
        tick();
        chk("tmo next snd", 32'(bus.mn_snd), 32'd1);
        chk("tmo next gnt", 32'(bus.gnt),    32'd2);
        finish_xfer(8'h77);
        chk("tmo next done1", 32'(bus.done1), 32'd1);
        chk("tmo next resp1", 32'(bus.resp1), 32'h77);
        chk("tmo resp0 kept", 32'(bus.resp0), 32'hFF);
        chk("tmo flag sticky", 32'(bus.tmo_err), 32'd1);
        tick();

        // Stale done held high, then reset in the middle of the transfer.
        b0 = dcnt0;
        send(1'b0, 16'h0D04);
        tick();
        chk("stale snd", 32'(bus.mn_snd), 32'd1);
        repeat (6) tick();
        chk("stale still owned", 32'(bus.gnt), 32'd1);
        chk("stale no done0", 32'(dcnt0 - b0), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        tick();
        rst = 1'b0;
        bs = scnt;
        repeat (6) tick();
        chk("midrst no snd", 32'(scnt - bs), 32'd0);
        chk("midrst no done", 32'(dcnt0 - b0), 32'd0);
        chk("midrst gnt idle", 32'(bus.gnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
